// File: rtl/alu_pipe_pack.sv
// Shared definitions for the pipelined accumulator ALU: opcode encoding and
// the bit positions of the status flags inside the 4-bit flags vector.
package alu_pipe_pack;

    typedef enum logic [2:0] {
        OPC_ADD = 3'd0,
        OPC_SUB = 3'd1,
        OPC_AND = 3'd2,
        OPC_OR  = 3'd3,
        OPC_XOR = 3'd4,
        OPC_SHL = 3'd5,
        OPC_SHR = 3'd6,
        OPC_MUL = 3'd7
    } opc_t;

    localparam int FLG_ZERO  = 0;
    localparam int FLG_NEG   = 1;
    localparam int FLG_CARRY = 2;
    localparam int FLG_OVF   = 3;

endpackage

// File: rtl/alu_core_comb.sv
// Combinational signed ALU datapath: result and {ovf, carry, neg, zero}.
// Build option: define ALU_SAT_EN to saturate ADD/SUB/MUL on signed overflow
// instead of wrapping modulo 2^WIDTH.
module alu_core_comb
    import alu_pipe_pack::*;
#(
    parameter int WIDTH = 8
) (
    input  opc_t             opc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

`ifdef ALU_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic sat_pos;
`endif

    logic [WIDTH:0]            sum;
    logic [WIDTH:0]            diff;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH:0]            prod_hi;
    logic signed [WIDTH-1:0]   a_s;
    logic [SHW-1:0]            shamt;
    logic [WIDTH-1:0]          res;
    logic                      ovf;
    logic                      carry;

    // Extra top bit of sum/diff is the unsigned carry-out / borrow.
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod  = a_ext * b_ext;
    // The product fits in WIDTH bits only if these bits are all equal.
    assign prod_hi = prod[2*WIDTH-1:WIDTH-1];
    assign a_s   = a;
    assign shamt = b[SHW-1:0];

    // Opcode decode, then optional saturation, then flag derivation.
    always_comb begin
        res   = '0;
        ovf   = 1'b0;
        carry = 1'b0;
`ifdef ALU_SAT_EN
        sat_pos = 1'b0;
`endif
        unique case (opc)
            OPC_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
                sat_pos = !a[WIDTH-1];
`endif
            end
            OPC_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
`ifdef ALU_SAT_EN
                sat_pos = !a[WIDTH-1];
`endif
            end
            OPC_AND: res = a & b;
            OPC_OR:  res = a | b;
            OPC_XOR: res = a ^ b;
            OPC_SHL: res = a << shamt;
            OPC_SHR: res = a_s >>> shamt;
            OPC_MUL: begin
                res = prod[WIDTH-1:0];
                ovf = !((&prod_hi) || !(|prod_hi));
`ifdef ALU_SAT_EN
                sat_pos = !prod[2*WIDTH-1];
`endif
            end
        endcase
`ifdef ALU_SAT_EN
        if (ovf) begin
            res = sat_pos ? MAX_POS : MAX_NEG;
        end
`endif
        result           = res;
        flags            = '0;
        flags[FLG_ZERO]  = (res == '0);
        flags[FLG_NEG]   = res[WIDTH-1];
        flags[FLG_CARRY] = carry;
        flags[FLG_OVF]   = ovf;
    end

endmodule

// File: rtl/alu_pipe_acc.sv
// Two-stage pipelined signed ALU with accumulator and valid/ready on both ends.
// Stage 1 holds the captured instruction; stage 2 is the output register.
// Build option: ALU_SAT_EN (saturating ADD/SUB/MUL, implemented in alu_core_comb).
module alu_pipe_acc
    import alu_pipe_pack::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opc,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_opc,
    output logic [3:0]       out_flags
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high. ready never depends on valid on the same side; a producer
    // that sees ready low must hold valid and its payload stable.

    logic             s1_valid;
    opc_t             s1_opc;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_valid;
    opc_t             s2_opc;
    logic [WIDTH-1:0] s2_result;
    logic [3:0]       s2_flags;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;

    logic adv;
    logic capture;
    logic execute;

    assign adv      = !s2_valid || out_ready;
    assign in_ready = !s1_valid || adv;
    assign capture  = in_valid && in_ready;
    assign execute  = adv && s1_valid;
    // Accumulator select is taken at execute time so chained ops see the
    // result written on the immediately preceding edge.
    assign op_a     = in_acc_sel ? acc : s1_a;

    alu_core_comb #(.WIDTH(WIDTH)) u_core (
        .opc    (s1_opc),
        .a      (op_a),
        .b      (s1_b),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // Stage 1: capture a new instruction, or empty when it moves on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_opc   <= OPC_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (capture) begin
            s1_valid <= 1'b1;
            s1_opc   <= opc_t'(in_opc);
            s1_a     <= in_a;
            s1_b     <= in_b;
        end else if (adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: load the executed result when the output slot is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_opc    <= OPC_ADD;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_opc    <= s1_opc;
                s2_result <= alu_result;
                s2_flags  <= alu_flags;
            end
        end
    end

    // Accumulator: follows every executed result; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (execute) begin
            acc <= alu_result;
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_opc    = s2_opc;
    assign out_flags  = s2_flags;

endmodule

// File: doc/alu_pipe_acc.md
Name: alu_pipe_acc

Overview:
- Parametrised, 2-stage pipelined signed ALU with a valid/ready handshake on input and output, and an internal accumulator register.
- Successor to the combinational opcode-enum ALU: same opcode set, generalised width, registered result, status flags, and accumulate mode.
- Sits between an instruction source (sequencer or bench driver) and a result consumer that may apply backpressure.

Parameters:
- WIDTH, 8: operand/result width in bits, signed two's complement; legal range 4..32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage 1 can accept an instruction this cycle.
- in_opc  in  3  opcode (opc_t).
- in_a  in  WIDTH  operand A, signed.
- in_b  in  WIDTH  operand B, signed.
- in_acc_sel  in  1  1 = replace operand A with the accumulator at execute.
- acc_clr  in  1  synchronous accumulator clear.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  result.
- out_opc  out  3  opcode of the result.
- out_flags  out  4  {ovf, carry, neg, zero}.

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, acc=0, out_valid=0, out_result=0, out_opc=ADD, out_flags=0. in_ready is 1 after reset.
- Opcodes (opc_t): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6 (arithmetic), MUL=7 (low WIDTH bits of the signed product).
- Stage 1 holds the captured instruction. Capture occurs when in_valid && in_ready.
- Stage 2 is the output register. adv = !s2_valid || out_ready.
- in_ready = !s1_valid || adv. This is combinational, with no dependency on in_valid.
- On adv && s1_valid: compute from stage 1 and load stage 2, setting s2_valid=1.
- On adv && !s1_valid: s2_valid=0.
- Latency: accepted at edge N, out_valid at edge N+1. Throughput is 1 per cycle when out_ready is held at 1.
- out_* remain stable while out_valid && !out_ready.
- Operand A = in_acc_sel ? acc : in_a. in_acc_sel is sampled at execute, not at capture.
- acc is loaded with the computed result on every execute.
- acc_clr=1 sets acc=0 at the edge. If acc_clr coincides with an execute, the clear wins.
- Back-to-back accumulate ops see the previous result with no bubble.
- Shifts: the shift amount is in_b[$clog2(WIDTH)-1:0], treated as unsigned. SHR sign-extends.
- Flags:
  - zero = (result==0).
  - neg = result[WIDTH-1].
  - carry = unsigned carry-out for ADD and borrow for SUB (a<b unsigned); 0 for all other opcodes.
  - ovf = signed overflow for ADD/SUB. For MUL, ovf=1 if the full 2*WIDTH product does not equal the sign-extended truncated result. ovf=0 otherwise.
- rst mid-operation: all in-flight instructions are discarded and no result is emitted.
- Simultaneous stall and new input: stage 1 is full and out_ready=0 gives in_ready=0. The driver must hold inputs stable.

Optional Feature:
- ALU_SAT_EN
  - Defined: ADD, SUB and MUL saturate when ovf=1, to 2^(WIDTH-1)-1 on positive overflow and -2^(WIDTH-1) on negative overflow. The ovf flag is still reported. zero and neg are computed from the saturated value. acc takes the saturated value.
  - Undefined: results wrap modulo 2^WIDTH.

Decomposition:
- Package alu_pipe_pack holds:
  - opc_t (enum logic [2:0]) and the flag bit-index constants (FLG_ZERO=0, FLG_NEG=1, FLG_CARRY=2, FLG_OVF=3).
  - Struct types are not placed in the package, because WIDTH varies per instance.
- Sub-module alu_core_comb: purely combinational, parametrised by WIDTH. Inputs are opc, a, b. Outputs are result and flags. The saturation logic lives inside it under ALU_SAT_EN.
- The top level holds the pipeline registers, handshake logic and accumulator.

Test Plan (WIDTH=8):
- ADD a=10, b=-5, out_ready=1 -> 1 cycle later out_valid=1, result=5, flags zero=0 neg=0 carry=1 ovf=0.
- Sweep all 8 opcodes with a=5, b=-5 -> ADD 0 (zero=1); SUB 10; AND 1; OR -1; XOR -2; SHL 5<<3=40; SHR 5>>>3=0; MUL -25.
- ADD a=100, b=100 -> without ALU_SAT_EN result=-56, ovf=1, neg=1. With ALU_SAT_EN result=127, ovf=1.
- Accumulate: acc_clr pulse, then ADD b=3 with in_acc_sel=1, repeated 4 times back-to-back -> results 3, 6, 9, 12 on consecutive cycles. acc_clr together with the 3rd op -> that op yields 9, the 4th yields 3.
- Backpressure: issue 3 ADDs with out_ready=0 -> in_ready drops after 2 accepted. out_result is held stable. Raising out_ready drains the results in order with none lost or duplicated.
- Assert rst for 1 cycle with 2 ops in flight -> out_valid=0 immediately (async), acc=0, in_ready=1. No stale result appears after reset.
